// File: rtl/refresh_scheduler.sv
// ============================================================================
// refresh_scheduler
// ----------------------------------------------------------------------------
// Purpose:
//    Schedules the periodic copy of data between three rotating memory banks.
//    One bank (cur_bank) holds the valid data. It is copied into the next bank
//    in sequence (cur_bank+1, wrapping 2 -> 0). When the destination bank
//    reports completion, that bank becomes the new cur_bank. User reads and
//    writes always go to the bank that currently owns the data. While a copy
//    is running, the bank wrappers redirect those accesses to the destination.
//
// Parameters:
//    REF_INTERVAL  IDLE cycles between refresh starts (4..65535)
//    REF_TIMEOUT   COPY cycles allowed before the copy is abandoned (130..65535)
//
// Ports:
//    clk        in   1  rising-edge clock
//    rst        in   1  asynchronous active-low reset
//    ref_force  in   1  start a refresh now (honoured only in IDLE)
//    u_re_in    in   1  user read request
//    u_we_in    in   1  user write request
//    ref_done   in   3  per-bank copy-complete flags (only the destination counts)
//    u_re       out  3  per-bank read enable, one-hot or zero
//    u_we       out  3  per-bank write enable, one-hot or zero
//    ref_en     out  3  per-bank refresh enable (bit = copy source)
//    start_SR   out  3  per-bank one-cycle copy-start pulse
//    cur_bank   out  2  bank holding valid data
//    rd_sel     out  2  bank that last received a read
//    ref_busy   out  1  refresh in progress (START or COPY)
//    ref_err    out  1  sticky copy-timeout flag
// ============================================================================
module refresh_scheduler #(
    parameter int REF_INTERVAL = 1024,
    parameter int REF_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ref_force,
    input  logic       u_re_in,
    input  logic       u_we_in,
    input  logic [2:0] ref_done,
    output logic [2:0] u_re,
    output logic [2:0] u_we,
    output logic [2:0] ref_en,
    output logic [2:0] start_SR,
    output logic [1:0] cur_bank,
    output logic [1:0] rd_sel,
    output logic       ref_busy,
    output logic       ref_err
);

    // Reload value of the IDLE down-counter and the last legal COPY count.
    localparam logic [15:0] INTERVAL_RELOAD = 16'(REF_INTERVAL - 1);
    localparam logic [15:0] TIMEOUT_LAST    = 16'(REF_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        COPY   = 2'd2,
        ROTATE = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_intervalCnt;
    logic [15:0] r_copyCnt;
    logic [1:0]  r_curBank;
    logic [1:0]  r_rdSel;
    logic [2:0]  r_refEn;
    logic [2:0]  r_startSr;
    logic        r_refBusy;
    logic        r_refErr;

    logic [1:0]  w_dstBank;
    logic [2:0]  w_curOneHot;
    logic        w_dstDone;

    // Destination is the next bank in the 0 -> 1 -> 2 -> 0 ring. Only the
    // destination's done flag may end a copy; the other two bits are noise.
    always_comb begin
        w_dstBank   = (r_curBank == 2'd2) ? 2'd0 : r_curBank + 2'd1;
        w_curOneHot = 3'b001 << r_curBank;
        w_dstDone   = ref_done[w_dstBank];
    end

    // Refresh state machine. All status outputs are registered here and are
    // set on the transition into the state they describe, so they line up
    // exactly with the state register. Any path back to IDLE reloads the
    // interval counter, which makes the spacing between starts independent
    // of how the previous refresh ended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_intervalCnt <= INTERVAL_RELOAD;
            r_copyCnt     <= '0;
            r_curBank     <= 2'd0;
            r_refEn       <= 3'b000;
            r_startSr     <= 3'b000;
            r_refBusy     <= 1'b0;
            r_refErr      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ref_force || (r_intervalCnt == 16'd0)) begin
                        r_state   <= START;
                        r_startSr <= w_curOneHot;
                        r_refEn   <= w_curOneHot;
                        r_refBusy <= 1'b1;
                    end else begin
                        r_intervalCnt <= r_intervalCnt - 16'd1;
                    end
                end
                START: begin
                    r_state   <= COPY;
                    r_startSr <= 3'b000;
                    r_copyCnt <= '0;
                end
                COPY: begin
                    // A done in the final allowed cycle still wins over the
                    // timeout, so a copy that just makes it is not discarded.
                    if (w_dstDone) begin
                        r_state   <= ROTATE;
                        r_refEn   <= 3'b000;
                        r_refBusy <= 1'b0;
                    end else if (r_copyCnt == TIMEOUT_LAST) begin
                        r_state       <= IDLE;
                        r_refEn       <= 3'b000;
                        r_refBusy     <= 1'b0;
                        r_refErr      <= 1'b1;
                        r_intervalCnt <= INTERVAL_RELOAD;
                    end else begin
                        r_copyCnt <= r_copyCnt + 16'd1;
                    end
                end
                ROTATE: begin
                    r_state       <= IDLE;
                    r_curBank     <= w_dstBank;
                    r_intervalCnt <= INTERVAL_RELOAD;
                end
                default: begin
                    r_state       <= IDLE;
                    r_refEn       <= 3'b000;
                    r_startSr     <= 3'b000;
                    r_refBusy     <= 1'b0;
                    r_intervalCnt <= INTERVAL_RELOAD;
                end
            endcase
        end
    end

    // Read-data mux select: remember which bank the most recent read went
    // to so the returning data can be picked from that bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdSel <= 2'd0;
        end else if (u_re_in) begin
            r_rdSel <= r_curBank;
        end
    end

    // User routing. In every state the target is the registered cur_bank:
    // during START/COPY that is the copy source (the wrapper forwards to the
    // destination), and during ROTATE the register still holds the old bank
    // until the end of the cycle. Reset gates the enables off directly since
    // the request inputs are not registered.
    always_comb begin
        u_re = 3'b000;
        u_we = 3'b000;
        if (rst) begin
            if (u_re_in) begin
                u_re = w_curOneHot;
            end
            if (u_we_in) begin
                u_we = w_curOneHot;
            end
        end
    end

    assign ref_en   = r_refEn;
    assign start_SR = r_startSr;
    assign cur_bank = r_curBank;
    assign rd_sel   = r_rdSel;
    assign ref_busy = r_refBusy;
    assign ref_err  = r_refErr;

endmodule

// File: tb/tb_refresh_scheduler.sv
// ============================================================================
// tb_refresh_scheduler
// ----------------------------------------------------------------------------
// Directed bench for refresh_scheduler with REF_INTERVAL=16 and
// REF_TIMEOUT=200. One linear sequence walks through reset, a periodic
// refresh with user traffic, a full bank rotation, a copy timeout and a
// reset in the middle of a copy. Expected values are written out by hand.
// ============================================================================
module tb_refresh_scheduler;

    logic       clk;
    logic       rst;
    logic       ref_force;
    logic       u_re_in;
    logic       u_we_in;
    logic [2:0] ref_done;
    logic [2:0] u_re;
    logic [2:0] u_we;
    logic [2:0] ref_en;
    logic [2:0] start_SR;
    logic [1:0] cur_bank;
    logic [1:0] rd_sel;
    logic       ref_busy;
    logic       ref_err;

    int compareCount;
    int failCount;
    int enCount;

    refresh_scheduler #(
        .REF_INTERVAL(16),
        .REF_TIMEOUT (200)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ref_force(ref_force),
        .u_re_in  (u_re_in),
        .u_we_in  (u_we_in),
        .ref_done (ref_done),
        .u_re     (u_re),
        .u_we     (u_we),
        .ref_en   (ref_en),
        .start_SR (start_SR),
        .cur_bank (cur_bank),
        .rd_sel   (rd_sel),
        .ref_busy (ref_busy),
        .ref_err  (ref_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and settle just after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive all user/refresh inputs in one go.
    task automatic applyStimulus(input logic force_, input logic re, input logic we,
                                 input logic [2:0] done);
        ref_force = force_;
        u_re_in   = re;
        u_we_in   = we;
        ref_done  = done;
    endtask

    // Single comparison point: counts it and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compareCount = 0;
        failCount    = 0;
        enCount      = 0;

        // Reset with requests asserted: every output must stay low.
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
        repeat (3) tick;
        checkOutput("rstRefEn",   16'(ref_en),   16'h0);
        checkOutput("rstStartSr", 16'(start_SR), 16'h0);
        checkOutput("rstBusy",    16'(ref_busy), 16'h0);
        checkOutput("rstErr",     16'(ref_err),  16'h0);
        checkOutput("rstCurBank", 16'(cur_bank), 16'h0);
        checkOutput("rstRdSel",   16'(rd_sel),   16'h0);
        checkOutput("rstURe",     16'(u_re),     16'h0);
        checkOutput("rstUWe",     16'(u_we),     16'h0);

        // Release; first start comes after exactly 16 IDLE cycles.
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        rst = 1'b1;
        for (int e = 1; e <= 15; e++) tick;
        checkOutput("preStartSr",   16'(start_SR), 16'h0);
        checkOutput("preStartBusy", 16'(ref_busy), 16'h0);
        tick;
        checkOutput("start0Sr",   16'(start_SR), 16'h1);
        checkOutput("start0En",   16'(ref_en),   16'h1);
        checkOutput("start0Busy", 16'(ref_busy), 16'h1);
        enCount = 1;

        // COPY from bank 0, done from bank 1 arrives 129 cycles after start.
        for (int k = 1; k <= 129; k++) begin
            tick;
            if (ref_en == 3'b001) enCount++;
            if (k == 1) begin
                checkOutput("startPulseOnce", 16'(start_SR), 16'h0);
            end
            if (k == 49) begin
                applyStimulus(1'b0, 1'b0, 1'b1, 3'b000);
                #1;
                checkOutput("copyWeRoute", 16'(u_we), 16'h1);
                checkOutput("copyReIdle",  16'(u_re), 16'h0);
                applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
            end
            if (k == 60) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 3'b101);
            end
            if (k == 61) begin
                checkOutput("misroutedBusy", 16'(ref_busy), 16'h1);
                checkOutput("misroutedEn",   16'(ref_en),   16'h1);
                applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
            end
            if (k == 129) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 3'b010);
            end
        end

        // ROTATE: enables drop, a read here still goes to the old bank.
        tick;
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000);
        #1;
        checkOutput("enHighCycles",  16'(enCount),  16'd130);
        checkOutput("rotateEn",      16'(ref_en),   16'h0);
        checkOutput("rotateBusy",    16'(ref_busy), 16'h0);
        checkOutput("rotateCurBank", 16'(cur_bank), 16'h0);
        checkOutput("rotateURe",     16'(u_re),     16'h1);

        // Back in IDLE with bank 1 owning the data.
        tick;
        checkOutput("curBank1",      16'(cur_bank), 16'h1);
        checkOutput("rdSelOldBank",  16'(rd_sel),   16'h0);
        checkOutput("idleReBank1",   16'(u_re),     16'h2);
        tick;
        checkOutput("rdSelBank1",    16'(rd_sel),   16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);

        // Periodic start from bank 1.
        for (int e = 2; e <= 15; e++) tick;
        checkOutput("pre2ndStart", 16'(start_SR), 16'h0);
        tick;
        checkOutput("start1Sr", 16'(start_SR), 16'h2);
        checkOutput("start1En", 16'(ref_en),   16'h2);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b100);
        tick;
        tick;
        checkOutput("rotate1En", 16'(ref_en), 16'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        tick;
        checkOutput("curBank2", 16'(cur_bank), 16'h2);

        // Simultaneous read and write both land on bank 2.
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
        #1;
        checkOutput("bothRe", 16'(u_re), 16'h4);
        checkOutput("bothWe", 16'(u_we), 16'h4);
        tick;
        checkOutput("rdSelBank2", 16'(rd_sel), 16'h2);

        // Forced refresh from bank 2 wraps back to bank 0.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        tick;
        checkOutput("start2Sr", 16'(start_SR), 16'h4);
        checkOutput("start2En", 16'(ref_en),   16'h4);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b001);
        tick;
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        tick;
        checkOutput("curBankWrap0", 16'(cur_bank), 16'h0);

        // Timeout: done never arrives, force during COPY must be ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        tick;
        checkOutput("startToSr", 16'(start_SR), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        enCount = 0;
        for (int k = 1; k <= 200; k++) begin
            tick;
            if (ref_en == 3'b001) enCount++;
            if (k == 5) ref_force = 1'b1;
            if (k == 6) ref_force = 1'b0;
        end
        checkOutput("toCopyCycles", 16'(enCount), 16'd200);
        tick;
        checkOutput("toEn",      16'(ref_en),   16'h0);
        checkOutput("toErr",     16'(ref_err),  16'h1);
        checkOutput("toCurBank", 16'(cur_bank), 16'h0);
        checkOutput("toBusy",    16'(ref_busy), 16'h0);
        tick;
        checkOutput("forceNotQueued", 16'(start_SR), 16'h0);

        // Next refresh starts from bank 0 again; error stays sticky.
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000);
        tick;
        checkOutput("retrySr",  16'(start_SR), 16'h1);
        checkOutput("errSticky", 16'(ref_err), 16'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);

        // Reset at COPY cycle 60 clears everything at once.
        for (int k = 1; k <= 60; k++) tick;
        checkOutput("preRstEn", 16'(ref_en), 16'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 3'b000);
        rst = 1'b0;
        #1;
        checkOutput("midRstEn",      16'(ref_en),   16'h0);
        checkOutput("midRstSr",      16'(start_SR), 16'h0);
        checkOutput("midRstBusy",    16'(ref_busy), 16'h0);
        checkOutput("midRstErr",     16'(ref_err),  16'h0);
        checkOutput("midRstURe",     16'(u_re),     16'h0);
        checkOutput("midRstUWe",     16'(u_we),     16'h0);
        checkOutput("midRstCurBank", 16'(cur_bank), 16'h0);
        checkOutput("midRstRdSel",   16'(rd_sel),   16'h0);

        // Release: no rotation happened, first start 16 cycles later.
        tick;
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000);
        rst = 1'b1;
        for (int e = 1; e <= 15; e++) tick;
        checkOutput("postRstCurBank", 16'(cur_bank), 16'h0);
        checkOutput("postRstNoStart", 16'(start_SR), 16'h0);
        tick;
        checkOutput("postRstStart", 16'(start_SR), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
